// File: rtl/poly_voice_mixer.sv
// Polyphonic voice mixer: captures per-voice samples, mixes them serially with per-voice
// mute and shift gain, saturates, and hands the result to the codec on each frame edge.
// Define POLY_MIXER_CLIP_STATS_EN to enable the saturating clip_count statistic.
module poly_voice_mixer #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               new_frame,
  input  logic                               play_enable,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]              voice_ready,
  input  logic [NUM_VOICES-1:0]              voice_mute,
  input  logic [NUM_VOICES*GAIN_WIDTH-1:0]   voice_gain,
  output logic                               generate_next_sample,
  output logic                               mix_valid,
  output logic [SAMPLE_WIDTH-1:0]            sample_out,
  output logic [3:0]                         active_voices,
  output logic                               overrun,
  output logic [15:0]                        clip_count
);

  localparam int ACC_W = SAMPLE_WIDTH + 3;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [SAMPLE_WIDTH-1:0] SAT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] SAT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

  state_t                         state_q, state_d;
  logic                           new_frame_q;
  logic [NUM_VOICES-1:0]          ready_mask;
  logic [NUM_VOICES-1:0]          capture_en;
  logic signed [SAMPLE_WIDTH-1:0] capture  [NUM_VOICES];
  logic signed [SAMPLE_WIDTH-1:0] snapshot [NUM_VOICES];
  logic signed [SAMPLE_WIDTH-1:0] sample_in [NUM_VOICES];
  logic [GAIN_WIDTH-1:0]          gain      [NUM_VOICES];
  logic signed [ACC_W-1:0]        acc;
  logic [IDX_W-1:0]               idx;
  logic [SAMPLE_WIDTH-1:0]        pending;
  logic                           fresh;
  logic                           trigger;
  logic signed [SAMPLE_WIDTH-1:0] shifted;
  logic signed [ACC_W-1:0]        term;
  logic [ACC_W-SAMPLE_WIDTH:0]    upper;
  logic                           clipped;
  logic [SAMPLE_WIDTH-1:0]        sat_val;
  logic [3:0]                     active_cnt;

  assign capture_en = voice_ready & {NUM_VOICES{play_enable}};
  assign trigger    = (state_q == IDLE) && (&ready_mask);
  assign mix_valid  = (state_q == SAT);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      sample_in[i] = voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      gain[i]      = voice_gain[i*GAIN_WIDTH +: GAIN_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (&ready_mask) state_d = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One voice per ACCUM cycle; the shift is arithmetic so negative samples stay negative.
  always_comb begin
    shifted = snapshot[idx] >>> gain[idx];
    term    = voice_mute[idx] ? '0 : {{(ACC_W-SAMPLE_WIDTH){shifted[SAMPLE_WIDTH-1]}}, shifted};
  end

  // The sum fits SAMPLE_WIDTH bits only when the top bits are all copies of the sign.
  always_comb begin
    upper   = acc[ACC_W-1:SAMPLE_WIDTH-1];
    clipped = !((&upper) || !(|upper));
    sat_val = acc[SAMPLE_WIDTH-1:0];
    if (clipped) sat_val = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
  end

  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!voice_mute[i] && (snapshot[i] != '0)) active_cnt = active_cnt + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the capture/snapshot arrays are reset too, so a mix right after reset sees zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      new_frame_q          <= 1'b0;
      generate_next_sample <= 1'b0;
      ready_mask           <= '0;
      acc                  <= '0;
      idx                  <= '0;
      pending              <= '0;
      sample_out           <= '0;
      fresh                <= 1'b0;
      overrun              <= 1'b0;
      active_voices        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        capture[i]  <= '0;
        snapshot[i] <= '0;
      end
    end else begin
      new_frame_q          <= new_frame;
      generate_next_sample <= new_frame & ~new_frame_q;

      for (int i = 0; i < NUM_VOICES; i++) begin
        if (capture_en[i]) capture[i] <= sample_in[i];
      end

      // Samples arriving during a mix belong to the next mix; the snapshot keeps this one stable.
      if (!play_enable) ready_mask <= '0;
      else              ready_mask <= (trigger ? '0 : ready_mask) | capture_en;

      if (trigger) begin
        for (int i = 0; i < NUM_VOICES; i++) snapshot[i] <= capture[i];
        acc <= '0;
        idx <= '0;
      end else if (state_q == ACCUM) begin
        acc <= acc + term;
        idx <= idx + IDX_W'(1);
      end

      if (state_q == SAT) begin
        pending       <= sat_val;
        active_voices <= active_cnt;
      end

      if (generate_next_sample) sample_out <= pending;

      if (mix_valid)                 fresh <= 1'b1;
      else if (generate_next_sample) fresh <= 1'b0;

      if (generate_next_sample && !fresh && play_enable) overrun <= 1'b1;
    end
  end

`ifdef POLY_MIXER_CLIP_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_count <= '0;
    end else if ((state_q == SAT) && clipped && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Scoreboard bench for poly_voice_mixer: stimulus pushes expected mixes and frame pulses,
// a negedge monitor pops them whenever the DUT presents mix_valid or generate_next_sample.
module tb_poly_voice_mixer;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int GW = 4;
  localparam int MIX_LAT = NV + 2;

  typedef struct {
    int sum;
    int active;
    bit clip;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              new_frame;
  logic              play_enable;
  logic [NV*SW-1:0]  voice_sample;
  logic [NV-1:0]     voice_ready;
  logic [NV-1:0]     voice_mute;
  logic [NV*GW-1:0]  voice_gain;
  logic              generate_next_sample;
  logic              mix_valid;
  logic [SW-1:0]     sample_out;
  logic [3:0]        active_voices;
  logic              overrun;
  logic [15:0]       clip_count;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int mix_seen = 0;

  exp_t          exp_q[$];
  int            gns_q[$];
  int            m_cap[NV];
  logic [NV-1:0] m_mask;
  int            m_pending, m_active, m_clips, exp_out;
  bit            m_fresh, m_overrun, chk_out, chk_stat;

  poly_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .new_frame            (new_frame),
    .play_enable          (play_enable),
    .voice_sample         (voice_sample),
    .voice_ready          (voice_ready),
    .voice_mute           (voice_mute),
    .voice_gain           (voice_gain),
    .generate_next_sample (generate_next_sample),
    .mix_valid            (mix_valid),
    .sample_out           (sample_out),
    .active_voices        (active_voices),
    .overrun              (overrun),
    .clip_count           (clip_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_clip_count();
`ifdef POLY_MIXER_CLIP_STATS_EN
    return (m_clips > 65535) ? 65535 : m_clips;
`else
    return 0;
`endif
  endfunction

  // Reference mix: plain integer sum of the captured values, then a clamp to the sample range.
  function automatic exp_t model_mix();
    exp_t e;
    int s = 0;
    int a = 0;
    for (int v = 0; v < NV; v++) begin
      if (!voice_mute[v]) begin
        s += m_cap[v] >>> voice_gain[v*GW +: GW];
        if (m_cap[v] != 0) a++;
      end
    end
    e.clip   = (s > 32767) || (s < -32768);
    e.sum    = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    e.active = a;
    e.cyc    = cyc + MIX_LAT;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (chk_out) begin
        check("sample_out", int'($signed(sample_out)), exp_out);
        check("overrun", int'(overrun), int'(m_overrun));
        chk_out = 1'b0;
      end
      if (chk_stat) begin
        check("active_voices", int'(active_voices), m_active);
        check("clip_count", int'(clip_count), exp_clip_count());
        chk_stat = 1'b0;
      end
      if (generate_next_sample) begin
        check("gns_cycle", cyc, (gns_q.size() > 0) ? gns_q.pop_front() : -1);
        if (!m_fresh && play_enable) m_overrun = 1'b1;
        exp_out = m_pending;
        chk_out = 1'b1;
      end
      if (mix_valid) begin
        exp_t e;
        e = '{sum: 0, active: 0, clip: 1'b0, cyc: -1};
        if (exp_q.size() > 0) e = exp_q.pop_front();
        mix_seen++;
        check("mix_cycle", cyc, e.cyc);
        m_pending = e.sum;
        m_active  = e.active;
        if (e.clip) m_clips++;
        chk_stat = 1'b1;
      end
      if (mix_valid)                 m_fresh = 1'b1;
      else if (generate_next_sample) m_fresh = 1'b0;
    end
  end

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_cap[v] = 0;
    m_mask = '0;
    m_pending = 0;
    m_active = 0;
    m_clips = 0;
    m_fresh = 1'b0;
    m_overrun = 1'b0;
    chk_out = 1'b0;
    chk_stat = 1'b0;
    exp_q.delete();
    gns_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic lvl);
    if (lvl && !new_frame) gns_q.push_back(cyc + 1);
    new_frame = lvl;
  endtask

  task automatic set_play(input logic lvl);
    play_enable = lvl;
    if (!lvl) m_mask = '0;
  endtask

  // Presents one cycle of voice_ready in the current cycle, then advances one cycle.
  task automatic drive_ready(input logic [NV-1:0] m, input int v[NV]);
    logic signed [SW-1:0] s16;
    for (int i = 0; i < NV; i++) begin
      s16 = SW'(v[i]);
      voice_sample[i*SW +: SW] = s16;
      if (m[i] && play_enable) begin
        m_cap[i]  = s16;
        m_mask[i] = 1'b1;
      end
    end
    voice_ready = m;
    if (&m_mask) begin
      exp_q.push_back(model_mix());
      m_mask = '0;
    end
    tick();
    voice_ready = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("mix_timeout_outstanding", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic frame_edge();
    if (new_frame) begin
      set_frame(1'b0);
      tick();
    end
    set_frame(1'b1);
    tick();
    set_frame(1'b0);
    tick();
    tick();
  endtask

  function automatic int rand_sample();
    case ($urandom_range(0, 4))
      0:       return 32767;
      1:       return -32768;
      2:       return 0;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    int vals[NV];
    int mark;
    logic [NV-1:0] sub;
    int j;

    reset_n = 1'b0;
    new_frame = 1'b0;
    play_enable = 1'b0;
    voice_sample = '0;
    voice_ready = '0;
    voice_mute = '0;
    voice_gain = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_out", int'(sample_out), 0);
    check("rst_mix_valid", int'(mix_valid), 0);
    check("rst_gns", int'(generate_next_sample), 0);
    check("rst_active", int'(active_voices), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_clip_count", int'(clip_count), 0);
    reset_n = 1'b1;
    tick();
    set_play(1'b1);

    // Plain sum, no gain or mute.
    drive_ready(4'hF, '{1000, 2000, 3000, 4000});
    wait_idle();
    frame_edge();
    check("basic_sum", int'($signed(sample_out)), 10000);
    check("basic_active", int'(active_voices), 4);

    // Positive and negative saturation.
    drive_ready(4'hF, '{28672, 28672, 28672, 28672});
    wait_idle();
    frame_edge();
    check("sat_pos", int'(sample_out), 32'h7FFF);
`ifdef POLY_MIXER_CLIP_STATS_EN
    check("sat_pos_clip_count", int'(clip_count), 1);
`else
    check("sat_pos_clip_count", int'(clip_count), 0);
`endif
    drive_ready(4'hF, '{-28672, -28672, -28672, -28672});
    wait_idle();
    frame_edge();
    check("sat_neg", int'(sample_out), 32'h8000);

    // Voice 1 muted, voice 2 attenuated by 4.
    voice_mute = 4'b0010;
    voice_gain = 16'h0200;
    drive_ready(4'hF, '{100, 200, 400, 800});
    wait_idle();
    frame_edge();
    check("mute_gain_sum", int'($signed(sample_out)), 1000);
    check("mute_gain_active", int'(active_voices), 3);
    voice_mute = '0;
    voice_gain = '0;

    // A new voice 0 sample during ACCUM must only reach the following mix.
    drive_ready(4'hF, '{10, 20, 30, 40});
    tick();
    tick();
    drive_ready(4'b0001, '{500, 0, 0, 0});
    wait_idle();
    frame_edge();
    check("accum_current_mix", int'($signed(sample_out)), 100);
    drive_ready(4'b1110, '{0, 1, 2, 3});
    wait_idle();
    frame_edge();
    check("accum_next_mix", int'($signed(sample_out)), 506);
    check("overrun_clear_before", int'(overrun), 0);

    // Frames with no new mix: sticky overrun, output unchanged.
    frame_edge();
    frame_edge();
    check("overrun_set", int'(overrun), 1);
    check("stale_sample_out", int'($signed(sample_out)), 506);

    for (int it = 0; it < 30; it++) begin
      wait_idle();
      voice_mute = NV'($urandom & $urandom);
      voice_gain = ($urandom_range(0, 3) == 0) ? (NV*GW)'($urandom) : (NV*GW)'($urandom) & 16'h3333;
      set_play(1'b1);
      for (int v = 0; v < NV; v++) vals[v] = rand_sample();
      drive_ready(4'hF, vals);
      j = $urandom_range(0, NV - 1);
      repeat ($urandom_range(1, 8)) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin
            for (int v = 0; v < NV; v++) vals[v] = rand_sample();
            sub = NV'($urandom) & ~(4'b0001 << j);
            drive_ready(sub, vals);
          end
          4, 5, 6: begin
            set_frame(~new_frame);
            tick();
          end
          7: begin
            set_play(~play_enable);
            tick();
          end
          default: tick();
        endcase
      end
    end
    wait_idle();
    set_frame(1'b0);
    repeat (4) tick();
    check("gns_outstanding", gns_q.size(), 0);

    // Asynchronous reset in the middle of ACCUM.
    set_play(1'b1);
    drive_ready(4'hF, '{1, 2, 3, 4});
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_sample_out", int'(sample_out), 0);
    check("midrst_mix_valid", int'(mix_valid), 0);
    check("midrst_gns", int'(generate_next_sample), 0);
    check("midrst_active", int'(active_voices), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_clip_count", int'(clip_count), 0);
    model_reset();
    new_frame = 1'b0;
    voice_ready = '0;
    tick();
    tick();
    reset_n = 1'b1;
    mark = mix_seen;
    repeat (10) tick();
    check("no_mix_after_reset", mix_seen - mark, 0);
    check("active_after_reset", int'(active_voices), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
